// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, default sizes and command type for the SRAM access controller
package sram_ctrl_pkg;
  localparam int ROWS_DEF = 16;
  localparam int COLS_DEF = 8;
  localparam int RD_TIMEOUT_DEF = 32;
  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, READ, WAIT_RD, RESP} state_t;
  typedef struct packed {
    logic                        write;
    logic [$clog2(ROWS_DEF)-1:0] addr;
    logic [COLS_DEF-1:0]         wdata;
  } cmd_t;
endpackage

// File: rtl/sram_ctrl_piso.sv
// sram_ctrl_piso: parallel-load LSB-first shift register feeding the SRAM serial input
module sram_ctrl_piso #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          load,
  input  logic          shift_en,
  input  logic [W-1:0]  din,
  output logic          serial_out,
  output logic [CW-1:0] count,
  output logic          done
);
  logic [W-1:0] sr;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      sr <= '0;
      count <= '0;
    end else if (load) begin
      sr <= din;
      count <= '0;
    end else if (shift_en) begin
      sr <= sr >> 1;
      count <= count + CW'(1);
    end
  assign serial_out = sr[0];
  assign done = shift_en && count == CW'(W - 1);
endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequences one read/write command at a time onto the sram_top serial-load interface
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int ROWS       = ROWS_DEF,
  parameter  int COLS       = COLS_DEF,
  parameter  int RD_TIMEOUT = RD_TIMEOUT_DEF,
  localparam int AW         = $clog2(ROWS),
  localparam int CW         = $clog2(COLS + 1),
  localparam int TW         = $clog2(RD_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [COLS-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy,
  output logic            sram_serial_in,
  output logic            sram_shift,
  output logic            sram_w_en,
  output logic            sram_r_en,
  output logic [AW-1:0]   sram_addr,
  input  logic            sram_data_valid,
  input  logic [COLS-1:0] sram_data_out
);
  state_t state, state_d;
  logic [TW-1:0] tmo;
  logic [CW-1:0] bit_cnt;
  logic hs, rd_hit, tmo_hit, rsp_hold, piso_done;
  logic cmd_ready_d, busy_d, sram_shift_d, sram_w_en_d, sram_r_en_d, rsp_valid_d, rsp_err_d;
  logic [COLS-1:0] rsp_rdata_d;
  logic [AW-1:0] sram_addr_d;
  assign hs = cmd_valid && cmd_ready;
  assign rd_hit = sram_data_valid && (state == READ || state == WAIT_RD);
  assign tmo_hit = state == WAIT_RD && tmo == TW'(RD_TIMEOUT - 1);
  assign rsp_hold = state == RESP && !rsp_ready;
  sram_ctrl_piso #(.W(COLS)) u_piso (
    .clk        (clk),
    .arst_n     (arst_n),
    .load       (hs && cmd_write),
    .shift_en   (state == SHIFT),
    .din        (cmd_wdata),
    .serial_out (sram_serial_in),
    .count      (bit_cnt),
    .done       (piso_done)
  );
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= IDLE;
      tmo <= '0;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      sram_shift <= 1'b0;
      sram_w_en <= 1'b0;
      sram_r_en <= 1'b0;
      sram_addr <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_d;
      tmo <= state == WAIT_RD ? tmo + TW'(1) : '0;
      cmd_ready <= cmd_ready_d;
      busy <= busy_d;
      sram_shift <= sram_shift_d;
      sram_w_en <= sram_w_en_d;
      sram_r_en <= sram_r_en_d;
      sram_addr <= sram_addr_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err <= rsp_err_d;
    end
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = hs ? (cmd_write ? SHIFT : READ) : IDLE;
      SHIFT:   state_d = piso_done ? WRITE : SHIFT;
      WRITE:   state_d = RESP;
      READ:    state_d = rd_hit ? RESP : WAIT_RD;
      WAIT_RD: state_d = rd_hit || tmo_hit ? RESP : WAIT_RD;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    sram_shift_d = state_d == SHIFT;
    sram_w_en_d = state_d == WRITE;
    sram_r_en_d = state_d == READ;
    rsp_valid_d = state_d == RESP;
    rsp_rdata_d = rsp_hold ? rsp_rdata : rd_hit ? sram_data_out : '0;
    rsp_err_d = rsp_hold ? rsp_err : tmo_hit && !rd_hit;
    sram_addr_d = hs ? cmd_addr : sram_addr;
  end
  assert property (@(posedge clk) disable iff (!arst_n) $onehot0({sram_shift, sram_w_en, sram_r_en}));
  assert property (@(posedge clk) disable iff (!arst_n) state != SHIFT || bit_cnt < CW'(COLS));
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed scoreboard bench for sram_access_ctrl against a behavioural sram_top
module tb_sram_access_ctrl;
  import sram_ctrl_pkg::*;
  localparam int ROWS = ROWS_DEF;
  localparam int COLS = COLS_DEF;
  localparam int RD_TIMEOUT = RD_TIMEOUT_DEF;
  localparam int AW = $clog2(ROWS);
  typedef struct {
    logic [COLS-1:0] rdata;
    logic            err;
  } rsp_t;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_err, busy;
  logic [AW-1:0] cmd_addr, sram_addr;
  logic [COLS-1:0] cmd_wdata, rsp_rdata;
  logic sram_serial_in, sram_shift, sram_w_en, sram_r_en, sram_data_valid;
  logic [COLS-1:0] sram_data_out = '0;
  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] sh_reg = '0;
  logic [AW-1:0] paddr = '0;
  logic pend = 1'b0, dv = 1'b0, dv_kill = 1'b0, dv_spur = 1'b0;
  rsp_t exp_q[$];
  rsp_t mon_e;
  int n_chk = 0, n_fail = 0;
  bit a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  sram_access_ctrl #(.ROWS(ROWS), .COLS(COLS), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .busy            (busy),
    .sram_serial_in  (sram_serial_in),
    .sram_shift      (sram_shift),
    .sram_w_en       (sram_w_en),
    .sram_r_en       (sram_r_en),
    .sram_addr       (sram_addr),
    .sram_data_valid (sram_data_valid),
    .sram_data_out   (sram_data_out)
  );
  always #5 clk = ~clk;
  assign sram_data_valid = dv | dv_spur;
  always @(posedge clk) begin
    if (sram_shift) sh_reg <= {sram_serial_in, sh_reg[COLS-1:1]};
    if (sram_w_en) mem[sram_addr] <= sh_reg;
    pend <= sram_r_en;
    if (sram_r_en) paddr <= sram_addr;
    dv <= pend && !dv_kill;
    if (pend) sram_data_out <= mem[paddr];
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (arst_n) begin
      check("strobe_excl", 32'($onehot0({sram_shift, sram_w_en, sram_r_en})), 1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rdata %0h err %0b, no response expected", rsp_rdata, rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
          check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end
    end
  end
  task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [COLS-1:0] d,
                        input logic [COLS-1:0] er, input logic ee, input bit push);
    int n = 0;
    rsp_t t;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no cmd_ready, expected accept within 200 cycles");
    end
    t.rdata = er;
    t.err = ee;
    if (push) exp_q.push_back(t);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got busy after 200 cycles, expected return to IDLE");
    end
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, sh, wen, ren, waits;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    #12;
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_strobes", 32'({sram_shift, sram_w_en, sram_r_en, sram_serial_in}), 0);
    check("rst_rsp", 32'({rsp_valid, rsp_err, busy, rsp_rdata, sram_addr}), 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    // Write 0xA5 to row 3 with a stray data_valid that must be ignored
    dv_spur = 1'b1;
    do_cmd(1'b1, AW'(3), 8'hA5, 8'h00, 1'b0, 1'b1);
    n = 1;
    sh = 0;
    wen = 0;
    while (!rsp_valid && n < 100) begin
      if (sram_shift) begin
        if (sh < 8) check("wr_serial", 32'(sram_serial_in), 32'(a5_bits[sh]));
        check("wr_shift_addr", 32'(sram_addr), 3);
        sh++;
      end
      if (sram_w_en) begin
        check("wr_wen_addr", 32'(sram_addr), 3);
        wen++;
      end
      n++;
      @(negedge clk);
    end
    check("wr_latency", 32'(n), 10);
    check("wr_shift_cycles", 32'(sh), 8);
    check("wr_wen_cycles", 32'(wen), 1);
    dv_spur = 1'b0;
    wait_idle();
    do_cmd(1'b0, AW'(3), 8'h00, 8'hA5, 1'b0, 1'b1);
    n = 0;
    ren = 0;
    while (!rsp_valid && n < 100) begin
      if (sram_r_en) begin
        check("rd_addr", 32'(sram_addr), 3);
        ren++;
      end
      n++;
      @(negedge clk);
    end
    check("rd_ren_cycles", 32'(ren), 1);
    wait_idle();
    // Read with the SRAM silent: exactly RD_TIMEOUT cycles in WAIT_RD
    dv_kill = 1'b1;
    do_cmd(1'b0, AW'(5), 8'h00, 8'h00, 1'b1, 1'b1);
    waits = 0;
    n = 0;
    while (!rsp_valid && n < 200) begin
      if (!sram_r_en) waits++;
      n++;
      @(negedge clk);
    end
    check("tmo_cycles", 32'(waits), 32'(RD_TIMEOUT));
    check("tmo_err", 32'(rsp_err), 1);
    check("tmo_rdata", 32'(rsp_rdata), 0);
    wait_idle();
    dv_kill = 1'b0;
    rsp_ready = 1'b0;
    do_cmd(1'b1, AW'(7), 8'h5A, 8'h00, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr = AW'(9);
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_rdata", 32'({rsp_err, rsp_rdata}), 0);
      check("bp_ready", 32'(cmd_ready), 0);
      check("bp_no_read", 32'(sram_r_en), 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", 32'({cmd_ready, busy, rsp_valid}), 32'b100);
    do_cmd(1'b0, AW'(7), 8'h00, 8'h5A, 1'b0, 1'b1);
    wait_idle();
    // Abort a write at shift bit 4; no response may follow
    do_cmd(1'b1, AW'(15), 8'hC3, 8'h00, 1'b0, 1'b0);
    sh = 0;
    n = 0;
    while (sh < 4 && n < 50) begin
      if (sram_shift) sh++;
      n++;
      @(negedge clk);
    end
    check("abort_at_shift", 32'(sram_shift), 1);
    arst_n = 1'b0;
    #1;
    check("abort_strobes", 32'({sram_shift, sram_w_en, sram_r_en}), 0);
    check("abort_ready", 32'({cmd_ready, busy, rsp_valid}), 32'b100);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'({rsp_valid, sram_w_en, cmd_ready}), 32'b001);
    end
    do_cmd(1'b1, AW'(15), 8'h3C, 8'h00, 1'b0, 1'b1);
    wait_idle();
    do_cmd(1'b0, AW'(15), 8'h00, 8'h3C, 1'b0, 1'b1);
    wait_idle();
    for (int a = 0; a < ROWS; a++) begin
      do_cmd(1'b1, AW'(a), 8'(255 - a), 8'h00, 1'b0, 1'b1);
      wait_idle();
    end
    for (int a = 0; a < ROWS; a++) begin
      do_cmd(1'b0, AW'(a), 8'h00, 8'(255 - a), 1'b0, 1'b1);
      wait_idle();
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Command sequencer in front of `sram_top`.
- Accepts one parallel read/write command at a time over a valid/ready interface.
- Writes: converts the word into `sram_top`'s serial shift-load protocol, then pulses the write strobe.
- Reads: pulses the read strobe, captures `data_out` on `data_valid` with a timeout, and returns a single response per command.

Parameters:
- ROWS, 16, number of SRAM words; address width is $clog2(ROWS).
- COLS, 8, word width in bits.
- RD_TIMEOUT, 32, maximum cycles to wait for `sram_data_valid` after the read strobe.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- arst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  $clog2(ROWS)  target row.
- cmd_wdata  input  COLS  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  COLS  read data; 0 for writes and timeouts.
- rsp_err  output  1  read timed out.
- busy  output  1  state != IDLE.
- sram_serial_in  output  1  to `sram_top.serial_in`.
- sram_shift  output  1  to `sram_top.shift`.
- sram_w_en  output  1  to `sram_top.w_en`.
- sram_r_en  output  1  to `sram_top.r_en`.
- sram_addr  output  $clog2(ROWS)  to `sram_top.addr`.
- sram_data_valid  input  1  from `sram_top.data_valid`.
- sram_data_out  input  COLS  from `sram_top.data_out`.

Behaviour:
- Reset: clk with arst_n asynchronous active-low. On reset, all outputs are 0 except cmd_ready=1, and state is IDLE. Asserting reset mid-operation aborts the command immediately; no response is produced.
- States: IDLE, SHIFT, WRITE, READ, WAIT_RD, RESP.
- Outputs are registered.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) latches write, addr and wdata, and drives sram_addr from the next cycle.
  - Transition to SHIFT on a write, READ on a read.
- SHIFT:
  - Lasts exactly COLS cycles with sram_shift=1.
  - sram_serial_in = wdata[i] in cycle i, i=0..COLS-1, LSB first.
  - A bit counter of width $clog2(COLS+1) moves to WRITE after the last bit.
- WRITE: one cycle, sram_w_en=1, sram_shift=0. Then RESP with rsp_err=0 and rsp_rdata=0.
- READ: one cycle, sram_r_en=1. Then WAIT_RD with the timeout counter cleared.
- WAIT_RD:
  - sram_data_valid is sampled from the READ cycle onward.
  - On the first valid, capture sram_data_out into rsp_rdata and go to RESP with rsp_err=0.
  - If RD_TIMEOUT cycles in WAIT_RD pass without a valid, go to RESP with rsp_err=1 and rsp_rdata=0.
- RESP:
  - rsp_valid=1 with data and err held stable until rsp_ready.
  - On rsp_valid & rsp_ready, return to IDLE; cmd_ready rises the next cycle, so there are no back-to-back accepts.
- sram_addr holds the latched address from acceptance through RESP and keeps its last value in IDLE.
- sram_w_en, sram_r_en and sram_shift are mutually exclusive, and each is asserted only in its own state.
- sram_data_valid outside READ/WAIT_RD is ignored.
- cmd_valid while busy: no accept, command held by the requester.
- Latency, write command: 1 (accept) + COLS + 1 cycles to rsp_valid.
- Latency, read command: 2 + SRAM read latency cycles to rsp_valid.

Decomposition:
- Package `sram_ctrl_pkg`:
  - state_t enum.
  - Default ROWS/COLS/RD_TIMEOUT localparams.
  - cmd_t struct {write, addr, wdata}.
- One sub-module, `sram_ctrl_piso`: COLS-bit parallel-load, LSB-first shift register with load, shift_en and done outputs. It generates sram_serial_in and the bit count.

Test Plan:
- Write (COLS=8): 0xA5 to addr 3 -> 8 shift cycles with serial_in 1,0,1,0,0,1,0,1 and addr=3, then one w_en cycle, then rsp_valid=1, rsp_err=0, rsp_rdata=0; 10 cycles from accept to rsp_valid.
- Read: addr 3 after the above write -> one r_en cycle with addr=3; on data_valid, rsp_rdata=0xA5, rsp_err=0.
- Timeout: read addr 5 with sram_data_valid forced low -> rsp_valid exactly RD_TIMEOUT cycles after WAIT_RD entry, with rsp_err=1 and rsp_rdata=0.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, a new cmd_valid is not accepted; release -> IDLE next cycle.
- Reset mid-shift: assert arst_n=0 at shift bit 4 -> all SRAM strobes 0 immediately and cmd_ready=1 after release, with no rsp_valid; a following write/read of 0x3C to addr 15 completes correctly.
- Full sweep: write ~addr pattern to all ROWS, read all back -> every rsp_rdata matches, and w_en/r_en/shift are never simultaneously high.
